// File: rtl/gf180mcu_latch_bank_wr_ctrl.sv
// Write sequencer for a bank of transparent-high latch words (latq cells).
// Accepts one write per valid/ready handshake and drives the shared D bus.
// It then opens exactly one E line, framed by a SETUP cycle and HOLD cycle(s).
// Optional build macro GF180MCU_LATWR_HOLD2_EN stretches HOLD to two cycles
// for extra hold margin on slow corners.
module gf180mcu_latch_bank_wr_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int OPEN_CYC = 1
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  D,
  output logic [DEPTH-1:0]  E,
  output logic              busy,
  output logic              addr_err
);

`ifdef GF180MCU_LATWR_HOLD2_EN
  localparam int HOLD_CYC = 2;
`else
  localparam int HOLD_CYC = 1;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [DEPTH-1:0]  enable_q, enable_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              wrAccept;
  logic              inRange;

  // A request is taken only in IDLE; the range check decides write vs. error pulse.
  assign wrAccept = (state_q == IDLE) && wr_valid;
  assign inRange  = 32'(wr_addr) < 32'(DEPTH);

  // State register; RN drops the sequence back to IDLE immediately.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; one down counter times both the OPEN window and HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wrAccept && inRange) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = 4'(OPEN_CYC - 1);
      end
      OPEN: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = 4'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values derived from the upcoming state so every pin comes from a flop.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    err_d   = wrAccept && !inRange;
    if (wrAccept && inRange) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      enable_d[i] = (state_d == OPEN) && (addr_q == ADDR_W'(i));
    end
  end

  // Output registers; reset clears E asynchronously so no latch is left open.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      addr_q   <= '0;
      data_q   <= '0;
      enable_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign wr_ready = ready_q;
  assign D        = data_q;
  assign E        = enable_q;
  assign busy     = busy_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_gf180mcu_latch_bank_wr_ctrl.sv
// Self-checking bench for gf180mcu_latch_bank_wr_ctrl.
// Instance A (default parameters) is compared every cycle against a
// transaction-level reference model. Instance B (DEPTH=3, OPEN_CYC=4) covers
// out-of-range requests and asynchronous reset in the middle of a write.
// Honours GF180MCU_LATWR_HOLD2_EN for the expected HOLD length.
module tb_gf180mcu_latch_bank_wr_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int OPEN_CYC = 1;
`ifdef GF180MCU_LATWR_HOLD2_EN
  localparam int HOLD_CYC = 2;
`else
  localparam int HOLD_CYC = 1;
`endif
  localparam int TOTAL    = OPEN_CYC + 1 + HOLD_CYC;
  localparam int B_DEPTH  = 3;
  localparam int B_OPEN   = 4;

  logic clk = 1'b0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  logic              rnA, validA, readyA, busyA, errA;
  logic [ADDR_W-1:0] addrA;
  logic [WIDTH-1:0]  dataA, dA;
  logic [DEPTH-1:0]  eA;

  logic              rnB, validB, readyB, busyB, errB;
  logic [1:0]        addrB;
  logic [WIDTH-1:0]  dataB, dB;
  logic [B_DEPTH-1:0] eB;

  gf180mcu_latch_bank_wr_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OPEN_CYC(OPEN_CYC)
  ) dutA (
    .CLK(clk), .RN(rnA), .wr_valid(validA), .wr_ready(readyA),
    .wr_addr(addrA), .wr_data(dataA), .D(dA), .E(eA),
    .busy(busyA), .addr_err(errA)
  );

  gf180mcu_latch_bank_wr_ctrl #(
    .WIDTH(WIDTH), .DEPTH(B_DEPTH), .ADDR_W(2), .OPEN_CYC(B_OPEN)
  ) dutB (
    .CLK(clk), .RN(rnB), .wr_valid(validB), .wr_ready(readyB),
    .wr_addr(addrB), .wr_data(dataB), .D(dB), .E(eB),
    .busy(busyB), .addr_err(errB)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycles left until idle and cycles since the accept edge.
  int               mBusyLeft;
  int               mSince;
  logic [ADDR_W-1:0] mAddr;
  logic [WIDTH-1:0] mD;
  logic             mErr;
  logic [WIDTH-1:0] expMem [DEPTH];
  logic [WIDTH-1:0] latMem [DEPTH];
  logic [WIDTH-1:0] prevD;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    validA = v;
    addrA  = a;
    dataA  = d;
  endtask

  task automatic checkOutput();
    logic [DEPTH-1:0] expE;
    expE = '0;
    if (mBusyLeft != 0 && mSince >= 1 && mSince <= OPEN_CYC) expE[mAddr] = 1'b1;
    check("A.D",        64'(dA),     64'(mD));
    check("A.E",        64'(eA),     64'(expE));
    check("A.ready",    64'(readyA), 64'(mBusyLeft == 0));
    check("A.busy",     64'(busyA),  64'(mBusyLeft != 0));
    check("A.addr_err", 64'(errA),   64'(mErr));
    check("A.onehot",   64'($countones(eA) > 1), 64'(0));
    check("A.DchgE",    64'((dA != prevD) && (eA != '0)), 64'(0));
    prevD = dA;
    for (int i = 0; i < DEPTH; i++) if (eA[i]) latMem[i] = dA;
  endtask

  // Advance the model with the inputs present at the coming edge, then sample.
  task automatic step();
    if (!rnA) begin
      mBusyLeft = 0;
      mSince    = 0;
      mD        = '0;
      mErr      = 1'b0;
    end else begin
      mErr = 1'b0;
      if (mBusyLeft == 0) begin
        if (validA) begin
          if (int'(addrA) < DEPTH) begin
            mD            = dataA;
            mAddr         = addrA;
            mBusyLeft     = TOTAL;
            mSince        = 0;
            expMem[addrA] = dataA;
          end else begin
            mErr = 1'b1;
          end
        end
      end else begin
        mBusyLeft--;
        mSince++;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int n;
    rnA = 1'b1; rnB = 1'b1;
    applyStimulus(1'b0, '0, '0);
    validB = 1'b0; addrB = '0; dataB = '0;
    prevD = '0;
    for (int i = 0; i < DEPTH; i++) begin
      expMem[i] = '0;
      latMem[i] = '0;
    end
    #1;
    rnA = 1'b0; rnB = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom), WIDTH'($urandom));
      step();
    end
    applyStimulus(1'b0, '0, '0);
    rnA = 1'b1; rnB = 1'b1;
    step();
    check("rst.D", 64'(dA), 64'(8'h00));
    check("rst.E", 64'(eA), 64'(4'b0000));
    check("rst.ready", 64'(readyA), 64'(1));
    check("rst.busy", 64'(busyA), 64'(0));
    check("rst.err", 64'(errA), 64'(0));

    // Single write addr=2 data=0xA5.
    applyStimulus(1'b1, 2'd2, 8'hA5);
    step();
    check("single.D.T0", 64'(dA), 64'(8'hA5));
    check("single.ready.T0", 64'(readyA), 64'(0));
    applyStimulus(1'b0, '0, '0);
    step();
    check("single.E.T1", 64'(eA), 64'(4'b0100));
    step();
    check("single.E.T2", 64'(eA), 64'(4'b0000));
    for (int i = 0; i < HOLD_CYC; i++) step();
    check("single.ready.end", 64'(readyA), 64'(1));
    check("single.D.end", 64'(dA), 64'(8'hA5));

    // Back-to-back with wr_valid held high.
    applyStimulus(1'b1, 2'd0, 8'h11);
    step();
    applyStimulus(1'b1, 2'd3, 8'h3C);
    n = 0;
    do begin
      step();
      n++;
    end while (!readyA && n < 20);
    check("b2b.spacing", 64'(n + 1), 64'(OPEN_CYC + 2 + HOLD_CYC));
    step();
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step();
    check("b2b.word0", 64'(latMem[0]), 64'(8'h11));
    check("b2b.word3", 64'(latMem[3]), 64'(8'h3C));

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom), WIDTH'($urandom));
      step();
    end
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < DEPTH; i++) check("rand.latch", 64'(latMem[i]), 64'(expMem[i]));

    // Out-of-range request on the DEPTH=3 instance.
    validB = 1'b1; addrB = 2'd3; dataB = 8'hFF;
    step();
    check("oor.err", 64'(errB), 64'(1));
    check("oor.E", 64'(eB), 64'(3'b000));
    check("oor.D", 64'(dB), 64'(8'h00));
    check("oor.ready", 64'(readyB), 64'(1));
    check("oor.busy", 64'(busyB), 64'(0));
    validB = 1'b0;
    step();
    check("oor.err.gone", 64'(errB), 64'(0));
    check("oor.ready2", 64'(readyB), 64'(1));

    // Reset asserted during the second OPEN cycle of a write.
    validB = 1'b1; addrB = 2'd2; dataB = 8'h77;
    step();
    check("midrst.D.T0", 64'(dB), 64'(8'h77));
    validB = 1'b0;
    step();
    check("midrst.E.T1", 64'(eB), 64'(3'b100));
    step();
    check("midrst.E.T2", 64'(eB), 64'(3'b100));
    #2;
    rnB = 1'b0;
    #1;
    check("midrst.E.async", 64'(eB), 64'(3'b000));
    check("midrst.busy.async", 64'(busyB), 64'(0));
    check("midrst.ready.async", 64'(readyB), 64'(1));
    check("midrst.D.async", 64'(dB), 64'(8'h00));
    #1;
    rnB = 1'b1;
    step();
    check("midrst.idle.busy", 64'(busyB), 64'(0));
    check("midrst.idle.E", 64'(eB), 64'(3'b000));
    validB = 1'b1; addrB = 2'd0; dataB = 8'h33;
    step();
    check("midrst.accept.busy", 64'(busyB), 64'(1));
    check("midrst.accept.D", 64'(dB), 64'(8'h33));
    validB = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("midrst.final.ready", 64'(readyB), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gf180mcu_latch_bank_wr_ctrl.md
Name: gf180mcu_latch_bank_wr_ctrl

Overview:
Write sequencer that drives the D and E pins of a bank of DEPTH x WIDTH transparent-high latches (latq cells). It accepts one write per valid/ready handshake and places data on the shared D bus. It then pulses exactly one E line, one-hot and glitch-free from flops, with guaranteed setup and hold margins around the open window. It sits directly upstream of the latch bank in latch-based register files.

Parameters:
WIDTH, 8, data bits per latch word (shared D bus width)
DEPTH, 4, number of latch words, i.e. number of E lines; range 2..64
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH
OPEN_CYC, 1, CLK cycles that E stays high; range 1..15

Ports:
CLK  input  1  clock, rising-edge active
RN  input  1  asynchronous active-low reset
wr_valid  input  1  write request valid
wr_ready  output  1  controller can accept a request this cycle
wr_addr  input  ADDR_W  target latch word
wr_data  input  WIDTH  data to write
D  output  WIDTH  shared latch data bus, registered
E  output  DEPTH  per-word latch enables, one-hot or zero, registered
busy  output  1  high whenever state != IDLE
addr_err  output  1  one-cycle pulse when a request with wr_addr >= DEPTH is accepted

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RN).
- Reset values: state=IDLE, D=0, E=0, wr_ready=1, busy=0, addr_err=0. RN assertion forces E=0 immediately, without waiting for CLK, including mid-sequence. No partial write may be left with E high.
- FSM states are IDLE, SETUP, OPEN, HOLD. All outputs come straight from flops, with no combinational path to E.
- IDLE: wr_ready=1. On wr_valid && wr_ready, capture addr and data.
  - If addr < DEPTH: load D<=wr_data and go to SETUP.
  - If addr >= DEPTH: D is unchanged, addr_err=1 for the next cycle only, and the FSM stays in IDLE. wr_ready stays 1.
- SETUP: 1 cycle. D is stable, E=0, wr_ready=0. Next state is OPEN, with E[addr]<=1 on that edge.
- OPEN: E[addr]=1 for exactly OPEN_CYC cycles, tracked by a 4-bit down counter. D holds. On the last cycle, E<=0 and the FSM goes to HOLD.
- HOLD: 1 cycle. E=0, D still holds. Next state is IDLE, with wr_ready<=1.
- Timing relative to the accept edge (T0):
  - D valid after T0.
  - E rises after T0+1.
  - E falls after T0+1+OPEN_CYC.
  - wr_ready returns after T0+2+OPEN_CYC.
  - Sustained throughput is one write per OPEN_CYC+3 cycles.
- D keeps the last written value in IDLE. It changes only on an accepted in-range request.
- wr_valid, wr_addr and wr_data are ignored while wr_ready=0. There is no queueing.
- Invariant: popcount(E) <= 1 at all times. E is never high in the same cycle that D changes.
- busy = (state != IDLE).

Optional Feature:
Macro GF180MCU_LATWR_HOLD2_EN.
- Defined: HOLD lasts 2 cycles, for extra hold margin on slow corners. wr_ready returns after T0+3+OPEN_CYC, and throughput is one write per OPEN_CYC+4 cycles.
- Undefined: HOLD lasts 1 cycle, as described above.
- All other behaviour is identical in both cases.

Test Plan:
Default parameters (WIDTH=8, DEPTH=4, OPEN_CYC=1), macro undefined, unless a line states otherwise.
- Reset: hold RN=0 with random inputs, release -> D=0x00, E=4'b0000, wr_ready=1, busy=0, addr_err=0.
- Single write addr=2, data=0xA5 accepted at edge T0 -> D=0xA5 after T0; E=4'b0100 only between T0+1 and T0+2; wr_ready=1 again after T0+3; D stays 0xA5.
- Back-to-back: hold wr_valid=1 with writes (0,0x11), (3,0x3C) -> accepts 4 cycles apart; E goes 0001 then 0011... no: E goes 4'b0001 then 4'b1000, never overlapping; a behavioural latch model ends holding 0x11 in word 0 and 0x3C in word 3.
- Out-of-range: parameters DEPTH=3, ADDR_W=2; write addr=3, data=0xFF -> addr_err high for 1 cycle, E stays 0, D unchanged, wr_ready stays 1.
- Reset mid-OPEN: parameter OPEN_CYC=4; drive RN=0 during the 2nd OPEN cycle -> E=0 within the same cycle, asynchronously; FSM in IDLE after RN release.
- Macro defined, OPEN_CYC=2, write addr=1: E high for exactly 2 cycles; wr_ready returns after T0+5; D is stable for 2 cycles after E falls.
